// File: rtl/ecall_io_responder.sv
// Responder for the fetch unit's ecall stall: services print/read/exit and resumes on a debounced
// continue-button press-and-release. Build option ECALL_READ_SIGNED_EN sign-extends the switch read.
module ecall_io_responder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ecall_valid,
    input  logic [7:0]  service,
    input  logic [31:0] arg,
    input  logic [15:0] switches,
    input  logic        continue_button,
    output logic        stall,
    output logic        resume,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic [31:0] display_value,
    output logic        display_valid,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WAIT_PRESS   = 3'd1,
        S_WAIT_RELEASE = 3'd2,
        S_DONE         = 3'd3,
        S_HALT         = 3'd4
    } state_t;

    localparam logic [7:0]       SVC_PRINT = 8'd1;
    localparam logic [7:0]       SVC_READ  = 8'd5;
    localparam logic [7:0]       SVC_EXIT  = 8'd10;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_db;
    logic              r_db_d;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_read;
    logic [31:0]       r_wb_data;
    logic [31:0]       r_display_value;
    logic              r_display_valid;
    logic              w_release_evt;
    logic              w_accept;
    logic [31:0]       w_read_ext;

    assign w_release_evt = r_db_d & ~r_db;
    assign w_accept      = (r_state == S_IDLE) && ecall_valid;

`ifdef ECALL_READ_SIGNED_EN
    assign w_read_ext = {{16{switches[15]}}, switches};
`else
    assign w_read_ext = {16'h0000, switches};
`endif

    // Button path: 2-FF synchronizer, then a level that flips only after a full stable window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= continue_button;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            if (r_sync2 != r_db) begin
                if (r_cnt == CNT_LAST) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (ecall_valid) begin
                    case (service)
                        SVC_PRINT, SVC_READ: w_next = S_WAIT_PRESS;
                        SVC_EXIT:            w_next = S_HALT;
                        default:             w_next = S_DONE;
                    endcase
                end
            end
            S_WAIT_PRESS:   if (r_db) w_next = S_WAIT_RELEASE;
            S_WAIT_RELEASE: if (w_release_evt) w_next = S_DONE;
            S_DONE:         w_next = S_IDLE;
            S_HALT:         w_next = S_HALT;
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall  = (r_state != S_IDLE);
        resume = (r_state == S_DONE);
        wb_en  = (r_state == S_DONE) && r_is_read;
        halted = (r_state == S_HALT);
    end

    // Service datapath: the display holds until the next print; wb_data is captured at release.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_read       <= 1'b0;
            r_wb_data       <= '0;
            r_display_value <= '0;
            r_display_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_is_read <= (service == SVC_READ);
                if (service == SVC_PRINT) begin
                    r_display_value <= arg;
                    r_display_valid <= 1'b1;
                end
            end
            if ((r_state == S_WAIT_RELEASE) && w_release_evt && r_is_read) begin
                r_wb_data <= w_read_ext;
            end
        end
    end

    assign wb_data       = r_wb_data;
    assign display_value = r_display_value;
    assign display_valid = r_display_valid;

endmodule

// File: tb/tb_ecall_io_responder.sv
// Bench for ecall_io_responder: randomized ecalls and button activity checked by a scoreboard
// fed from a service-level reference model.
module tb_ecall_io_responder;

    localparam int DEB   = 4;
    localparam int EXP_W = 66;  // {is_read, wb_data[31:0], display_valid, display_value[31:0]}

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ecall_valid = 1'b0;
    logic [7:0]  service = '0;
    logic [31:0] arg = '0;
    logic [15:0] switches = '0;
    logic        continue_button = 1'b0;
    logic        stall;
    logic        resume;
    logic        wb_en;
    logic [31:0] wb_data;
    logic [31:0] display_value;
    logic        display_valid;
    logic        halted;

    logic [EXP_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    // Reference model state: what the board display should show.
    logic [31:0] m_disp;
    logic        m_disp_valid;

    ecall_io_responder #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .ecall_valid     (ecall_valid),
        .service         (service),
        .arg             (arg),
        .switches        (switches),
        .continue_button (continue_button),
        .stall           (stall),
        .resume          (resume),
        .wb_en           (wb_en),
        .wb_data         (wb_data),
        .display_value   (display_value),
        .display_valid   (display_valid),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] read_model(input logic [15:0] sw);
`ifdef ECALL_READ_SIGNED_EN
        return (sw >= 16'h8000) ? (32'(sw) + 32'hFFFF_0000) : 32'(sw);
`else
        return 32'(sw);
`endif
    endfunction

    // Monitor: every resume pulse must match the oldest outstanding expectation.
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (resume) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resume", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_en_at_resume", 32'(wb_en), 32'(e[65]));
                        if (e[65]) check("wb_data", wb_data, e[64:33]);
                        check("display_valid", 32'(display_valid), 32'(e[32]));
                        check("display_value", display_value, e[31:0]);
                    end
                end else if (wb_en) begin
                    check("wb_en_without_resume", 32'd1, 32'd0);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ecall_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_disp = '0;
        m_disp_valid = 1'b0;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_resume", 32'(resume), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_display_value", display_value, 32'd0);
        check("rst_display_valid", 32'(display_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100; i++) begin
            if (!stall) break;
            @(negedge clk);
        end
        if (i == 100) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [7:0] svc, input logic [31:0] a, input logic [15:0] sw);
        wait_idle();
        if (svc == 8'd1) begin
            m_disp = a;
            m_disp_valid = 1'b1;
        end
        if (svc != 8'd10) exp_q.push_back({svc == 8'd5, read_model(sw), m_disp_valid, m_disp});
        service = svc;
        arg = a;
        switches = sw;
        ecall_valid = 1'b1;
        @(negedge clk);
        ecall_valid = 1'b0;
        service = $urandom_range(0, 255);
        arg = $urandom;
        check("stall_after_accept", 32'(stall), 32'd1);
        if (svc == 8'd1) begin
            check("print_display_value", display_value, a);
            check("print_display_valid", 32'(display_valid), 32'd1);
        end
        if (svc != 8'd1 && svc != 8'd5 && svc != 8'd10) begin
            check("unknown_resume_latency", 32'(resume), 32'd1);
            @(negedge clk);
            check("unknown_stall_drop", 32'(stall), 32'd0);
        end
    endtask

    task automatic press(input int hold);
        continue_button = 1'b1;
        repeat (hold) @(negedge clk);
        check("stall_while_pressed", 32'(stall), 32'd1);
    endtask

    // Release and expect resume after synchronizer (2) + stable window (DEB) + one cycle.
    task automatic release_wait();
        int lat;
        continue_button = 1'b0;
        for (lat = 1; lat <= 30; lat++) begin
            @(negedge clk);
            if (resume) break;
        end
        check("release_latency_ok", 32'(lat >= DEB + 1 && lat <= DEB + 4), 32'd1);
        @(negedge clk);
        check("stall_after_resume", 32'(stall), 32'd0);
    endtask

    initial begin
        logic [7:0] svc;
        m_disp = '0;
        m_disp_valid = 1'b0;
        do_reset();

        // Directed print, then read of a negative-looking switch value.
        issue(8'd1, 32'h0000_002A, 16'h1234);
        press(10);
        release_wait();
        issue(8'd5, $urandom, 16'hFFFE);
        press(10);
        release_wait();

        // Bouncing button never settles: no level change, no resume.
        issue(8'd5, $urandom, 16'($urandom_range(0, 65535)));
        for (int i = 0; i < 10; i++) begin
            continue_button = ~continue_button;
            repeat (2) @(negedge clk);
            check("bounce_stall", 32'(stall), 32'd1);
            check("bounce_no_resume", 32'(resume), 32'd0);
        end
        press(10);
        release_wait();

        // Button already held when the ecall arrives.
        continue_button = 1'b1;
        repeat (10) @(negedge clk);
        issue(8'd1, $urandom, 16'h0);
        repeat (3) @(negedge clk);
        release_wait();

        // Randomized mix of print, read and unknown services.
        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 2))
                0: svc = 8'd1;
                1: svc = 8'd5;
                default: begin
                    do svc = 8'($urandom_range(0, 255));
                    while (svc == 8'd1 || svc == 8'd5 || svc == 8'd10);
                end
            endcase
            issue(svc, $urandom, 16'($urandom_range(0, 65535)));
            if (svc == 8'd1 || svc == 8'd5) begin
                press($urandom_range(DEB + 4, DEB + 10));
                release_wait();
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Unknown service then exit; exit ignores everything until reset.
        issue(8'd7, $urandom, 16'h0);
        issue(8'd10, $urandom, 16'h0);
        check("exit_halted", 32'(halted), 32'd1);
        check("exit_resume", 32'(resume), 32'd0);
        for (int i = 0; i < 6; i++) begin
            ecall_valid = 1'b1;
            service = 8'd1;
            arg = $urandom;
            continue_button = ~continue_button;
            repeat (DEB + 4) @(negedge clk);
            check("halt_stall", 32'(stall), 32'd1);
            check("halt_halted", 32'(halted), 32'd1);
        end
        ecall_valid = 1'b0;
        continue_button = 1'b0;
        check("halt_display_unchanged", display_value, m_disp);
        do_reset();

        // Reset while a read waits for release: abandoned, everything cleared.
        repeat (10) @(negedge clk);
        issue(8'd1, 32'hDEAD_BEEF, 16'h0);
        press(10);
        release_wait();
        issue(8'd5, $urandom, 16'hABCD);
        press(DEB + 8);
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_mid_no_resume", 32'(resume), 32'd0);
            check("rst_mid_no_wb_en", 32'(wb_en), 32'd0);
        end
        reset = 1'b0;
        m_disp = '0;
        m_disp_valid = 1'b0;
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_display_value", display_value, 32'd0);
        check("rst_mid_display_valid", 32'(display_valid), 32'd0);
        check("rst_mid_wb_data", wb_data, 32'd0);
        continue_button = 1'b0;
        repeat (15) @(negedge clk);

        // Normal operation after the reset.
        issue(8'd5, $urandom, 16'h7FFF);
        press(10);
        release_wait();

        repeat (3) @(negedge clk);
        check("all_responses_seen", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
